// File: rtl/tracker_pkg.sv
// Shared types for the tracker / aim-scheduler slice.
// Region count, coordinate type and scheduler states.
package tracker_pkg;
   localparam int N_REGION = 16;
   localparam int REGION_W = 4;
   localparam int COORD_W  = 10;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DWELL,
      HOME
   } sched_state_t;
endpackage

// File: rtl/rr_pick16.sv
// Round-robin picker: first set mask bit after last_idx,
// wrapping mod 16; last_idx itself is tried last.
module rr_pick16
   import tracker_pkg::*;
(
   input  logic [N_REGION-1:0] mask,
   input  logic [REGION_W-1:0] last_idx,
   output logic [REGION_W-1:0] idx,
   output logic                found
);
   logic [REGION_W-1:0] cand;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= N_REGION; i++) begin
         cand = last_idx + REGION_W'(i);
         if (!found && mask[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/aim_scheduler.sv
// Turns per-frame region detections into round-robin aim commands
// with a dwell per target and a park-at-home command on target_off.
module aim_scheduler
   import tracker_pkg::*;
#(
   parameter int COORD_W   = 10,
   parameter int DWELL_CYC = 2_500_000,
   parameter int HOME_X    = 320,
   parameter int HOME_Y    = 240
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             v_sync,
   input  logic [N_REGION-1:0]              det_all,
   input  logic [N_REGION-1:0][COORD_W-1:0] aim_x_all,
   input  logic [N_REGION-1:0][COORD_W-1:0] aim_y_all,
   input  logic                             target_off,
   output logic                             cmd_valid,
   input  logic                             cmd_ready,
   output logic [COORD_W-1:0]               cmd_x,
   output logic [COORD_W-1:0]               cmd_y,
   output logic [REGION_W-1:0]              cmd_region,
   output logic                             cmd_home,
   output logic                             aim_lock,
   output logic                             busy,
   output logic [7:0]                       overrun_cnt
);
   localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CNT_LOAD = cnt_t'(DWELL_CYC - 1);

   sched_state_t state_q, state_d;
   logic vs_q, vs_d, rise_q, rise_d, toff_q, toff_d;
   logic [N_REGION-1:0] pend_q, pend_d;
   logic [N_REGION-1:0][COORD_W-1:0] snap_x_q, snap_x_d;
   logic [N_REGION-1:0][COORD_W-1:0] snap_y_q, snap_y_d;
   logic [REGION_W-1:0] last_q, last_d, region_q, region_d;
   logic home_sent_q, home_sent_d;
   cnt_t cnt_q, cnt_d;
   logic valid_q, valid_d, home_q, home_d, lock_q, lock_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [7:0] ovr_q, ovr_d;

   logic [REGION_W-1:0] pick_idx;
   logic pick_found, hs, toff_rise;

   rr_pick16 u_pick (
      .mask     (pend_q),
      .last_idx (last_q),
      .idx      (pick_idx),
      .found    (pick_found)
   );

   assign hs        = valid_q & cmd_ready;
   assign toff_rise = target_off & ~toff_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found)
               state_d = ISSUE;
            else if (target_off && !home_sent_q)
               state_d = HOME;
         end
         ISSUE:   if (hs) state_d = DWELL;
         DWELL:   if (toff_rise || cnt_q == '0) state_d = IDLE;
         HOME:    if (hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vs_d        = v_sync;
      rise_d      = v_sync & ~vs_q;
      toff_d      = target_off;
      pend_d      = pend_q;
      snap_x_d    = snap_x_q;
      snap_y_d    = snap_y_q;
      last_d      = last_q;
      home_sent_d = home_sent_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      x_d         = x_q;
      y_d         = y_q;
      region_d    = region_q;
      home_d      = home_q;
      lock_d      = 1'b0;
      ovr_d       = ovr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               valid_d  = 1'b1;
               region_d = pick_idx;
               x_d      = snap_x_q[pick_idx];
               y_d      = snap_y_q[pick_idx];
               home_d   = 1'b0;
            end else if (target_off && !home_sent_q) begin
               valid_d  = 1'b1;
               region_d = '0;
               x_d      = COORD_W'(HOME_X);
               y_d      = COORD_W'(HOME_Y);
               home_d   = 1'b1;
            end
         end
         ISSUE: begin
            if (hs) begin
               valid_d          = 1'b0;
               pend_d[region_q] = 1'b0;
               last_d           = region_q;
               cnt_d            = CNT_LOAD;
            end
         end
         DWELL: begin
            if (!toff_rise) begin
               if (cnt_q == '0) lock_d = 1'b1;
               else             cnt_d  = cnt_q - cnt_t'(1);
            end
         end
         HOME: begin
            if (hs) begin
               valid_d     = 1'b0;
               home_sent_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (!target_off) home_sent_d = 1'b0;
      // A new frame snapshot wins over a same-cycle handshake clear.
      if (rise_q) begin
         pend_d   = det_all;
         snap_x_d = aim_x_all;
         snap_y_d = aim_y_all;
         if (pend_q != '0 && ovr_q != 8'hFF)
            ovr_d = ovr_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q        <= 1'b0;
         rise_q      <= 1'b0;
         toff_q      <= 1'b0;
         pend_q      <= '0;
         snap_x_q    <= '0;
         snap_y_q    <= '0;
         last_q      <= '1;
         home_sent_q <= 1'b0;
         cnt_q       <= '0;
         valid_q     <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         region_q    <= '0;
         home_q      <= 1'b0;
         lock_q      <= 1'b0;
         ovr_q       <= '0;
      end else begin
         vs_q        <= vs_d;
         rise_q      <= rise_d;
         toff_q      <= toff_d;
         pend_q      <= pend_d;
         snap_x_q    <= snap_x_d;
         snap_y_q    <= snap_y_d;
         last_q      <= last_d;
         home_sent_q <= home_sent_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         x_q         <= x_d;
         y_q         <= y_d;
         region_q    <= region_d;
         home_q      <= home_d;
         lock_q      <= lock_d;
         ovr_q       <= ovr_d;
      end
   end

   always_comb begin
      cmd_valid   = valid_q;
      cmd_x       = x_q;
      cmd_y       = y_q;
      cmd_region  = region_q;
      cmd_home    = home_q;
      aim_lock    = lock_q;
      busy        = (state_q != IDLE);
      overrun_cnt = ovr_q;
   end
endmodule

// File: tb/tb_aim_scheduler.sv
// Bench for aim_scheduler: directed tables, corner sequences and
// random frames checked against a round-robin reference model.
module tb_aim_scheduler;
   localparam int CW = 10;
   localparam int DW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic v_sync = 1'b0;
   logic target_off = 1'b0;
   logic cmd_ready = 1'b0;
   logic [15:0] det_all = '0;
   logic [15:0][CW-1:0] aim_x_all = '0;
   logic [15:0][CW-1:0] aim_y_all = '0;
   logic cmd_valid, cmd_home, aim_lock, busy;
   logic [CW-1:0] cmd_x, cmd_y;
   logic [3:0] cmd_region;
   logic [7:0] overrun_cnt;

   aim_scheduler #(
      .COORD_W(CW), .DWELL_CYC(DW), .HOME_X(320), .HOME_Y(240)
   ) dut (
      .clk(clk), .reset_n(reset_n), .v_sync(v_sync),
      .det_all(det_all), .aim_x_all(aim_x_all),
      .aim_y_all(aim_y_all), .target_off(target_off),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_region(cmd_region),
      .cmd_home(cmd_home), .aim_lock(aim_lock), .busy(busy),
      .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int fx[16];
   int fy[16];

   typedef struct {
      logic [15:0] mask;
      int          n;
      int          ord[4];
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coords(input int s);
      for (int i = 0; i < 16; i++) begin
         fx[i] = (i * 13 + s * 37 + 5) & 1023;
         fy[i] = (i * 29 + s * 11 + 3) & 1023;
      end
   endtask

   task automatic drive_coords();
      for (int i = 0; i < 16; i++) begin
         aim_x_all[i] = CW'(fx[i]);
         aim_y_all[i] = CW'(fy[i]);
      end
   endtask

   task automatic start_frame(input logic [15:0] m);
      det_all = m;
      drive_coords();
      v_sync = 1'b1;
      step();
      v_sync = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic serve(input int r, input int x, input int y,
                        input bit home, input bit rnd, input bit lock);
      int n;
      bit hs;
      int want;
      n = 0;
      hs = 1'b0;
      while (!cmd_valid && n < 60) begin
         step();
         n++;
      end
      chk("cmd_seen", int'(cmd_valid), 1);
      if (!cmd_valid) return;
      chk("cmd_region", int'(cmd_region), r);
      chk("cmd_x", int'(cmd_x), x);
      chk("cmd_y", int'(cmd_y), y);
      chk("cmd_home", int'(cmd_home), int'(home));
      want = int'({1'b1, 4'(r), CW'(x), CW'(y)});
      n = 0;
      do begin
         cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = cmd_ready;
         step();
         n++;
         if (!hs)
            chk("hold_stable",
                int'({cmd_valid, cmd_region, cmd_x, cmd_y}), want);
      end while (!hs && n < 60);
      if (!hs) chk("hs_timeout", 0, 1);
      chk("valid_drop", int'(cmd_valid), 0);
      if (lock) begin
         for (int k = 1; k <= DW; k++) begin
            step();
            chk("lock_timing", int'(aim_lock), (k == DW) ? 1 : 0);
         end
      end
   endtask

   initial begin
      int cnt;
      int last;
      bit saw_lock, saw_home;
      logic [15:0] m;

      tbl[0] = '{16'h0001, 1, '{0, 0, 0, 0}};
      tbl[1] = '{16'h0001, 1, '{0, 0, 0, 0}};
      tbl[2] = '{16'h8421, 4, '{5, 10, 15, 0}};
      tbl[3] = '{16'h0006, 2, '{1, 2, 0, 0}};
      tbl[4] = '{16'h0003, 2, '{0, 1, 0, 0}};
      tbl[5] = '{16'hC000, 2, '{14, 15, 0, 0}};

      #2 reset_n = 1'b0;
      step();
      step();
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_outs", int'({cmd_x, cmd_y, cmd_region, cmd_home}), 0);
      chk("rst_lock_busy", int'({aim_lock, busy}), 0);
      chk("rst_overrun", int'(overrun_cnt), 0);
      reset_n = 1'b1;
      step();

      // single target with exact latency
      for (int i = 0; i < 16; i++) begin
         fx[i] = 0;
         fy[i] = 0;
      end
      fx[5] = 200;
      fy[5] = 150;
      cmd_ready = 1'b1;
      start_frame(16'h0020);
      step();
      chk("t1_not_early", int'(cmd_valid), 0);
      step();
      chk("t1_valid_a2", int'(cmd_valid), 1);
      chk("t1_busy", int'(busy), 1);
      serve(5, 200, 150, 1'b0, 1'b0, 1'b1);
      step();
      chk("t1_idle", int'({busy, cmd_valid}), 0);

      // round robin from reset state
      do_reset();
      set_coords(1);
      start_frame(16'h8003);
      serve(0, fx[0], fy[0], 1'b0, 1'b0, 1'b1);
      serve(1, fx[1], fy[1], 1'b0, 1'b0, 1'b1);
      serve(15, fx[15], fy[15], 1'b0, 1'b0, 1'b1);
      step();
      step();
      chk("t2_idle", int'({busy, cmd_valid}), 0);

      for (int t = 0; t < 6; t++) begin
         set_coords(t + 2);
         start_frame(tbl[t].mask);
         for (int j = 0; j < tbl[t].n; j++)
            serve(tbl[t].ord[j], fx[tbl[t].ord[j]], fy[tbl[t].ord[j]],
                  1'b0, 1'b0, 1'b1);
         step();
         chk("tbl_idle", int'({busy, cmd_valid}), 0);
      end

      // backpressure while a new frame lands
      set_coords(9);
      cmd_ready = 1'b0;
      start_frame(16'h0011);
      cnt = 0;
      while (!cmd_valid && cnt < 20) begin
         step();
         cnt++;
      end
      chk("t3_valid", int'(cmd_valid), 1);
      chk("t3_region", int'(cmd_region), 0);
      for (int i = 0; i < 10; i++) begin
         cmd_ready = 1'b0;
         if (i == 2) begin
            for (int k = 0; k < 16; k++) begin
               aim_x_all[k] = CW'(k * 17 + 100);
               aim_y_all[k] = CW'(k * 19 + 50);
            end
            det_all = 16'h0300;
            v_sync = 1'b1;
         end
         if (i == 3) v_sync = 1'b0;
         step();
         chk("t3_stable",
             int'({cmd_valid, cmd_region, cmd_x, cmd_y}),
             int'({1'b1, 4'd0, CW'(fx[0]), CW'(fy[0])}));
      end
      chk("t3_overrun", int'(overrun_cnt), 1);
      serve(0, fx[0], fy[0], 1'b0, 1'b0, 1'b1);
      serve(8, 8 * 17 + 100, 8 * 19 + 50, 1'b0, 1'b0, 1'b1);
      serve(9, 9 * 17 + 100, 9 * 19 + 50, 1'b0, 1'b0, 1'b1);
      step();
      step();
      chk("t3_idle", int'({busy, cmd_valid}), 0);

      // park at home once per target_off assertion
      target_off = 1'b1;
      serve(0, 320, 240, 1'b1, 1'b0, 1'b0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (cmd_valid) cnt++;
      end
      chk("t4_no_repeat", cnt, 0);
      target_off = 1'b0;
      step();
      step();
      target_off = 1'b1;
      serve(0, 320, 240, 1'b1, 1'b0, 1'b0);
      target_off = 1'b0;
      step();

      // target_off rising during dwell aborts the lock
      set_coords(4);
      start_frame(16'h0004);
      serve(2, fx[2], fy[2], 1'b0, 1'b0, 1'b0);
      step();
      target_off = 1'b1;
      saw_lock = 1'b0;
      saw_home = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cmd_ready = 1'b1;
         step();
         if (aim_lock) saw_lock = 1'b1;
         if (cmd_valid && cmd_home && cmd_x == CW'(320)) saw_home = 1'b1;
      end
      chk("t5_no_lock", int'(saw_lock), 0);
      chk("t5_home", int'(saw_home), 1);
      target_off = 1'b0;
      step();

      // overrun saturation
      do_reset();
      cmd_ready = 1'b0;
      det_all = 16'h0001;
      for (int f = 0; f < 260; f++) begin
         v_sync = 1'b1;
         step();
         v_sync = 1'b0;
         step();
         if (f == 254) chk("ovr_254", int'(overrun_cnt), 254);
      end
      step();
      chk("ovr_sat", int'(overrun_cnt), 255);

      // asynchronous reset while a command is pending
      chk("t6_pre_valid", int'(cmd_valid), 1);
      reset_n = 1'b0;
      #1;
      chk("t6_async_valid", int'(cmd_valid), 0);
      chk("t6_async_outs",
          int'({cmd_x, cmd_y, cmd_region, cmd_home, aim_lock, busy}), 0);
      chk("t6_async_ovr", int'(overrun_cnt), 0);
      step();
      reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cmd_ready = 1'b1;
         step();
         if (cmd_valid || busy) cnt++;
      end
      chk("t6_pend_clear", cnt, 0);

      // random frames against round-robin model
      do_reset();
      last = 15;
      for (int f = 0; f < 30; f++) begin
         m = 16'($urandom);
         if (m == '0) m = 16'(1) << $urandom_range(0, 15);
         for (int i = 0; i < 16; i++) begin
            fx[i] = int'($urandom_range(0, 1023));
            fy[i] = int'($urandom_range(0, 1023));
         end
         start_frame(m);
         for (int k = 1; k <= 16; k++) begin
            if (m[(last + k) % 16]) begin
               serve((last + k) % 16, fx[(last + k) % 16],
                     fy[(last + k) % 16], 1'b0, 1'b1, 1'b1);
               last = (last + k) % 16;
               k = 0;
               m[last] = 1'b0;
            end
         end
         step();
         chk("rnd_idle", int'({busy, cmd_valid}), 0);
      end
      chk("rnd_overrun", int'(overrun_cnt), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
